// File: rtl/ch_we_sched.sv
// ch_we_sched: turns ch_we register write requests into slot-aligned table writes.
// The slot counter follows sync_in, and the write enable rises only in the slot
// where the datapath already addresses the target channel.
module ch_we_sched #(
  parameter int unsigned CH_BITS = 9,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        ctrl_reg,
  input  logic               sync_in,
  output logic [CH_BITS-1:0] tbl_addr,
  output logic               tbl_we,
  output logic [DATA_W-1:0]  tbl_data,
  output logic               busy,
  output logic               ack,
  output logic               err_nosync
);

  localparam int unsigned N     = 2 ** CH_BITS;
  localparam int unsigned CNT_W = CH_BITS + 1;
  localparam logic [CNT_W-1:0]   ARM_LAST   = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0]   BCAST_LAST = CNT_W'(N);
  localparam logic [CH_BITS-1:0] ADDR_LAST  = CH_BITS'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_SLOT,
    S_BCAST,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CH_BITS-1:0] tbl_addr_q, tbl_addr_d;
  logic               tbl_we_q, tbl_we_d;
  logic [DATA_W-1:0]  tbl_data_q, tbl_data_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               sync_seen_q, sync_seen_d;
  logic               mode_q, mode_d;
  logic [CH_BITS-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  // Shared counter: no-sync timeout in ARMED, write count in BCAST.
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Bits 29..(16+CH_BITS) and any data bits above DATA_W carry no meaning here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_reg;

  // Next-state, slot counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tbl_we_d    = 1'b0;
    ack_d       = ack_q;
    err_d       = err_q;
    mode_d      = mode_q;
    tgt_d       = tgt_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    sync_seen_d = sync_seen_q | sync_in;
    tbl_addr_d  = sync_in ? '0 : tbl_addr_q + CH_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (ctrl_reg[31] != ack_q) begin
          mode_d  = ctrl_reg[30];
          tgt_d   = ctrl_reg[30] ? '0 : ctrl_reg[16 +: CH_BITS];
          data_d  = ctrl_reg[DATA_W-1:0];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = sync_seen_q ? S_WAIT_SLOT : S_ARMED;
        end
      end
      S_ARMED: begin
        if (sync_in) begin
          state_d = S_WAIT_SLOT;
        end else if (cnt_q == ARM_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_SLOT: begin
        // Compare against the next slot so we/addr/data land in the same cycle.
        if (!mode_q) begin
          if (tbl_we_q) begin
            state_d = S_DONE;
          end else if (tbl_addr_d == tgt_q) begin
            tbl_we_d = 1'b1;
          end
        end else if (tbl_addr_d == tgt_q) begin
          tbl_we_d = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = S_BCAST;
        end
      end
      S_BCAST: begin
        // A misaligned sync restarts the sweep so every slot is still covered.
        if (sync_in && (tbl_addr_q != ADDR_LAST)) begin
          tbl_we_d = 1'b1;
          cnt_d    = CNT_W'(1);
        end else if (cnt_q == BCAST_LAST) begin
          state_d = S_DONE;
        end else begin
          tbl_we_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        ack_d   = ~ack_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tbl_data_d = tbl_we_d ? data_q : tbl_data_q;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      tbl_addr_q  <= '0;
      tbl_we_q    <= 1'b0;
      tbl_data_q  <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      sync_seen_q <= 1'b0;
      mode_q      <= 1'b0;
      tgt_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      tbl_we_q    <= tbl_we_d;
      tbl_data_q  <= tbl_data_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      sync_seen_q <= sync_seen_d;
      mode_q      <= mode_d;
      tgt_q       <= tgt_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tbl_addr   = tbl_addr_q;
  assign tbl_we     = tbl_we_q;
  assign tbl_data   = tbl_data_q;
  assign busy       = busy_q;
  assign ack        = ack_q;
  assign err_nosync = err_q;

endmodule

// File: tb/tb_ch_we_sched.sv
// Directed bench for ch_we_sched: reset, no-sync timeout, single write,
// field change while busy, broadcast, misaligned-sync broadcast, reset mid-op.
module tb_ch_we_sched;

  logic        clk;
  logic        user_rst;
  logic [31:0] ctrl_reg;
  logic        sync_in;
  logic [8:0]  tbl_addr;
  logic        tbl_we;
  logic [15:0] tbl_data;
  logic        busy;
  logic        ack;
  logic        err_nosync;

  ch_we_sched #(.CH_BITS(9), .DATA_W(16)) dut (
    .user_clk   (clk),
    .user_rst   (user_rst),
    .ctrl_reg   (ctrl_reg),
    .sync_in    (sync_in),
    .tbl_addr   (tbl_addr),
    .tbl_we     (tbl_we),
    .tbl_data   (tbl_data),
    .busy       (busy),
    .ack        (ack),
    .err_nosync (err_nosync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          sph      = 0;
  bit          auto_sync = 0;
  logic [15:0] exp_data = '0;

  // Write monitor state
  int          we_cnt, data_bad, seq_bad, run, max_run, ack_tog, wr_cyc, ack_cyc;
  logic [8:0]  last_addr, first_addr;
  logic [511:0] mask;
  logic        prev_we  = 1'b0;
  logic        prev_ack = 1'b0;

  function automatic logic [31:0] mk(input bit req, input bit mode, input int ch,
                                     input logic [15:0] d);
    return {req, mode, 5'b0, 9'(ch), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    we_cnt = 0; data_bad = 0; seq_bad = 0; run = 0; max_run = 0; ack_tog = 0;
    mask = '0; wr_cyc = 0; ack_cyc = 0; last_addr = '0; first_addr = '0;
  endtask

  // One clock: sample outputs 1 ns after the edge, then drive periodic sync.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ack !== prev_ack) begin
      ack_tog++;
      ack_cyc = cyc;
    end
    prev_ack = ack;
    if (tbl_we === 1'b1) begin
      if (we_cnt == 0) first_addr = tbl_addr;
      if (prev_we === 1'b1 && tbl_addr !== last_addr + 9'd1) seq_bad++;
      run = (prev_we === 1'b1) ? run + 1 : 1;
      if (run > max_run) max_run = run;
      we_cnt++;
      mask[tbl_addr] = 1'b1;
      last_addr = tbl_addr;
      wr_cyc = cyc;
      if (tbl_data !== exp_data) data_bad++;
    end
    prev_we = tbl_we;
    if (auto_sync) begin
      sync_in = (sph == 511);
      sph = (sph == 511) ? 0 : sph + 1;
    end
  endtask

  task automatic wait_ack(input logic v, input int budget, output int used);
    used = 0;
    while (ack !== v && used < budget) begin
      tick();
      used++;
    end
  endtask

  initial begin
    int  used;
    bit  found;
    user_rst = 1'b1;
    ctrl_reg = '0;
    sync_in  = 1'b0;
    clear_mon();

    // Reset values
    repeat (3) tick();
    chk("rst_addr", 32'(tbl_addr), 32'd0);
    chk("rst_we", 32'(tbl_we), 32'd0);
    chk("rst_data", 32'(tbl_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err_nosync), 32'd0);
    user_rst = 1'b0;
    repeat (3) tick();

    // No sync ever seen: ARMED times out after 1024 cycles, no write
    ctrl_reg = mk(1, 0, 3, 16'h0055);
    exp_data = 16'h0055;
    clear_mon();
    tick();
    chk("nosync_busy", 32'(busy), 32'd1);
    wait_ack(1'b1, 1100, used);
    chk("nosync_ack", 32'(ack), 32'd1);
    chk("nosync_latency", 32'(used), 32'd1025);
    chk("nosync_err", 32'(err_nosync), 32'd1);
    chk("nosync_busy_end", 32'(busy), 32'd0);
    chk("nosync_no_we", 32'(we_cnt), 32'd0);

    // Start periodic sync and let one arrive
    auto_sync = 1;
    sph = 0;
    repeat (520) tick();

    // Single write ch 5, 0xBEEF; also clears err_nosync
    ctrl_reg = mk(0, 0, 5, 16'hBEEF);
    exp_data = 16'hBEEF;
    clear_mon();
    tick();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_err_clr", 32'(err_nosync), 32'd0);
    wait_ack(1'b0, 600, used);
    chk("single_ack", 32'(ack), 32'd0);
    chk("single_latency_ok", 32'(used <= 514), 32'd1);
    chk("single_we_cnt", 32'(we_cnt), 32'd1);
    chk("single_addr", 32'(last_addr), 32'd5);
    chk("single_data", 32'(data_bad), 32'd0);
    chk("single_ack_gap", 32'(ack_cyc - wr_cyc), 32'd2);
    chk("single_busy_end", 32'(busy), 32'd0);

    // Field change while busy: write must land at 300 only
    ctrl_reg = mk(1, 0, 300, 16'h0A0A);
    exp_data = 16'h0A0A;
    clear_mon();
    tick();
    chk("field_busy", 32'(busy), 32'd1);
    ctrl_reg = mk(1, 0, 7, 16'h7777);
    wait_ack(1'b1, 600, used);
    chk("field_ack", 32'(ack), 32'd1);
    chk("field_we_cnt", 32'(we_cnt), 32'd1);
    chk("field_addr", 32'(last_addr), 32'd300);
    chk("field_data", 32'(data_bad), 32'd0);

    // Broadcast 0x1234
    ctrl_reg = mk(0, 1, 0, 16'h1234);
    exp_data = 16'h1234;
    clear_mon();
    tick();
    chk("bcast_busy", 32'(busy), 32'd1);
    wait_ack(1'b0, 1100, used);
    chk("bcast_ack", 32'(ack), 32'd0);
    chk("bcast_latency_ok", 32'(used <= 1026), 32'd1);
    chk("bcast_we_cnt", 32'(we_cnt), 32'd512);
    chk("bcast_cover", 32'(&mask), 32'd1);
    chk("bcast_first", 32'(first_addr), 32'd0);
    chk("bcast_run", 32'(max_run), 32'd512);
    chk("bcast_seq", 32'(seq_bad), 32'd0);
    chk("bcast_data", 32'(data_bad), 32'd0);
    chk("bcast_ack_gap", 32'(ack_cyc - wr_cyc), 32'd2);
    chk("bcast_busy_end", 32'(busy), 32'd0);

    // Broadcast with a misaligned sync at address 200
    auto_sync = 0;
    sync_in = 1'b0;
    ctrl_reg = mk(1, 1, 0, 16'h4321);
    exp_data = 16'h4321;
    clear_mon();
    tick();
    chk("mis_busy", 32'(busy), 32'd1);
    found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      tick();
      if (tbl_we === 1'b1 && tbl_addr === 9'd200) found = 1;
    end
    chk("mis_reach_200", 32'(found), 32'd1);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("mis_restart_addr", 32'(tbl_addr), 32'd0);
    wait_ack(1'b1, 700, used);
    repeat (20) tick();
    chk("mis_ack", 32'(ack), 32'd1);
    chk("mis_we_cnt", 32'(we_cnt), 32'd713);
    chk("mis_cover", 32'(&mask), 32'd1);
    chk("mis_run", 32'(max_run), 32'd713);
    chk("mis_seq", 32'(seq_bad), 32'd1);
    chk("mis_data", 32'(data_bad), 32'd0);
    chk("mis_ack_tog", 32'(ack_tog), 32'd1);
    chk("mis_busy_end", 32'(busy), 32'd0);

    // Reset during WAIT_SLOT for ch 400
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (tbl_addr === 9'd10) found = 1;
    end
    chk("rmid_reach_10", 32'(found), 32'd1);
    ctrl_reg = mk(0, 0, 400, 16'hDEAD);
    exp_data = 16'hDEAD;
    clear_mon();
    tick();
    chk("rmid_busy", 32'(busy), 32'd1);
    repeat (50) tick();
    chk("rmid_no_early_we", 32'(we_cnt), 32'd0);
    user_rst = 1'b1;
    tick();
    chk("rmid_addr", 32'(tbl_addr), 32'd0);
    chk("rmid_we", 32'(tbl_we), 32'd0);
    chk("rmid_data", 32'(tbl_data), 32'd0);
    chk("rmid_busy0", 32'(busy), 32'd0);
    chk("rmid_ack", 32'(ack), 32'd0);
    chk("rmid_err", 32'(err_nosync), 32'd0);
    tick();
    user_rst = 1'b0;
    clear_mon();
    repeat (600) tick();
    chk("rmid_no_we", 32'(we_cnt), 32'd0);
    chk("rmid_no_ack", 32'(ack_tog), 32'd0);
    chk("rmid_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ch_we_sched.md
# ch_we_sched

Scheduler that turns software write requests, arriving through the 32-bit `ch_we` PPC-to-Simulink register, into slot-aligned writes to a 512-entry per-channel table. The table is a read-first single-port RAM shared with the time-multiplexed channelizer datapath. The datapath owns the address bus and steps through channels once per frame. This block tracks the channel slot from `sync_in` and asserts the write enable only in the cycle where the datapath is already addressing the target channel, so the datapath's read sequence is never disturbed. It sits in the `user_clk` domain between the register's `user_data_out` and the table RAM.

## Interface
- `CH_BITS`, 9: channel index width; frame length is N = 2^CH_BITS slots.
- `DATA_W`, 16: table data width; must be ≤ 16.
- `user_clk` in 1: sole clock, rising edge.
- `user_rst` in 1: reset, synchronous, active-high.
- `ctrl_reg` in 32: `ch_we` register value. Bit fields:
  - [31] `req` toggle.
  - [30] `mode`: 0 = single write, 1 = broadcast to all channels.
  - [16+CH_BITS-1:16] target channel.
  - [DATA_W-1:0] data.
- `sync_in` in 1: one-cycle pulse; channel 0 occupies the cycle after the pulse.
- `tbl_addr` out CH_BITS: current channel slot; drives the RAM address; shared with the datapath read.
- `tbl_we` out 1: RAM write enable.
- `tbl_data` out DATA_W: RAM write data.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `ack` out 1: completion toggle, returned to software through a Simulink-to-PPC register.
- `err_nosync` out 1: no sync arrived while waiting for alignment.

## Operation
- Slot counter:
  - `tbl_addr` <= 0 in the cycle after `sync_in` = 1; otherwise `tbl_addr`+1, wrapping N-1 → 0.
  - Free-runs whether or not a request is active.
- `sync_seen` flag: set by the first `sync_in` after reset; cleared only by reset.
- Handshake:
  - A request is pending when `ctrl_reg[31]` != `ack`.
  - Software issues the next request only after `ack` == `req`.
  - Fields are latched on acceptance; later changes to `ctrl_reg` while busy are ignored.
- FSM states: IDLE, ARMED, WAIT_SLOT, BCAST, DONE.
  - IDLE → ARMED: pending request and `sync_seen` = 0. Latch fields. Clear `err_nosync`.
  - IDLE → WAIT_SLOT (mode 0) or BCAST_WAIT via WAIT_SLOT with target 0 (mode 1): pending request and `sync_seen` = 1. Latch fields. Clear `err_nosync`.
  - ARMED → WAIT_SLOT: on `sync_in`.
  - ARMED → DONE: after 2N cycles without `sync_in`. Set `err_nosync`. No write is issued.
  - WAIT_SLOT, mode 0: one write cycle when `tbl_addr` == target, then → DONE.
  - WAIT_SLOT, mode 1: enter BCAST in the cycle `tbl_addr` == 0, which is also the first write.
  - BCAST: `tbl_we` = 1 on N consecutive cycles covering addresses 0..N-1, then → DONE.
  - BCAST with `sync_in` arriving while `tbl_addr` != N-1 (misaligned sync): the broadcast write count restarts, so the next cycle (address 0) counts as write 1. Full coverage of 0..N-1 is still guaranteed.
  - DONE: toggle `ack`, then → IDLE. Takes one cycle.
- `tbl_data` = latched data during write cycles; it holds its last value otherwise.
- `sync_in` asserted while in WAIT_SLOT: realigns the counter. The target compare uses the new count, so exactly one write is still issued.

## Timing
- Reset values: `tbl_addr` 0, `tbl_we` 0, `tbl_data` 0, `busy` 0, `ack` 0, `err_nosync` 0; state IDLE; `sync_seen` 0.
- `ack` resets to 0. If `ctrl_reg[31]` = 1 out of reset, a request is immediately pending; this is intended.
- All outputs are registered. `tbl_we`, `tbl_addr` and `tbl_data` are mutually aligned in the same cycle.
- Acceptance: the FSM leaves IDLE on the edge after the pending condition is first seen; `busy` rises on that edge.
- Single-write latency, `sync_seen` = 1: accept → write ≤ N cycles; write → `ack` toggle = 2 cycles; `busy` falls together with the `ack` toggle.
- Broadcast: ≤ N cycles waiting for address 0, then N write cycles, then `ack` 2 cycles after the last write.
- Reset mid-operation: all outputs take their reset values on the next edge. A write in progress is dropped, and no `ack` toggle is produced.

## Test plan
- Single write: sync every 512 cycles; request ch 5, data 0xBEEF, `req` 0→1. Expect exactly one `tbl_we` cycle with `tbl_addr` = 5 and `tbl_data` = 0xBEEF, and `ack` = 1 within 514 cycles of acceptance.
- Broadcast: data 0x1234, mode 1. Expect 512 consecutive `tbl_we` cycles at addresses 0..511, data 0x1234 throughout, then `ack` toggles and `busy` falls.
- No sync: after reset, no `sync_in`; issue a request. Expect ARMED, then `err_nosync` = 1 and `ack` toggled after 1024 cycles, with `tbl_we` never asserted. The next request clears `err_nosync`.
- Field change while busy: change the channel from 300 to 7 during WAIT_SLOT. Expect the write at 300 only.
- Misaligned sync during broadcast, at `tbl_addr` = 200. Expect the broadcast to restart, giving 201 + 512 write cycles in total, every address written with the latched data, and a single `ack` toggle.
- Reset mid-operation: assert `user_rst` during WAIT_SLOT for ch 400. Expect all outputs at reset values on the next edge and no write at 400.
